// File: rtl/pc_control_fsm.sv
// pc_control_fsm: multi-cycle control FSM for the RV32I subset (R, I-ALU, LOAD, STORE, BEQ/BNE).
// Sequences fetch/decode/execute/memory/writeback, drives the PC update strobe and next-PC select,
// waits on a memory ready handshake with an optional timeout, and counts retired instructions.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_i          synchronous active-high reset
//   opcode_i         instr[6:0] from the instruction register
//   funct3_i         instr[14:12] from the instruction register
//   zero_i           ALU zero flag, valid in EXECUTE
//   mem_ready_i      memory completes the current access this cycle
//   pc_write_o       PC loads the next address
//   sinal_mux_o      next-PC select: 0 = PC+4, 1 = PC+imm
//   ir_write_o       instruction register captures the fetched word
//   imem_read_o      instruction fetch request
//   dmem_read_o      data load request
//   dmem_write_o     data store request
//   reg_write_o      register-file write enable
//   alu_src_o        ALU operand B: 0 = rs2, 1 = immediate
//   mem_to_reg_o     writeback source: 0 = ALU, 1 = load data
//   alu_op_o         00 add, 01 subtract/compare, 10 funct-decoded
//   state_o          current state encoding
//   halted_o         high in HALT
//   timeout_o        sticky, HALT was entered through a memory timeout
//   instr_count_o    retired-instruction count (wraps silently)

module pc_control_fsm #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             sinal_mux_o,
    output logic             ir_write_o,
    output logic             imem_read_o,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic             reg_write_o,
    output logic             alu_src_o,
    output logic             mem_to_reg_o,
    output logic [1:0]       alu_op_o,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] instr_count_o
);

    localparam logic [2:0] StFetch     = 3'd0;
    localparam logic [2:0] StDecode    = 3'd1;
    localparam logic [2:0] StExecute   = 3'd2;
    localparam logic [2:0] StMemory    = 3'd3;
    localparam logic [2:0] StWriteback = 3'd4;
    localparam logic [2:0] StHalt      = 3'd7;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    // Counter only needs to hold 0 .. WAIT_LIMIT-1; the last value triggers the timeout.
    localparam int unsigned    WaitW    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);
    localparam bit             WaitEn   = (WAIT_LIMIT != 0);

    logic [2:0]       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    logic is_r, is_ialu, is_load, is_store, is_branch, legal;
    logic taken, wait_expired, retire;
    logic [WaitW-1:0] wait_inc;

    assign is_r      = (opcode_i == OpR);
    assign is_ialu   = (opcode_i == OpIAlu);
    assign is_load   = (opcode_i == OpLoad);
    assign is_store  = (opcode_i == OpStore);
    // Only beq (000) and bne (001) are supported.
    assign is_branch = (opcode_i == OpBranch) && (funct3_i[2:1] == 2'b00);
    assign legal     = is_r | is_ialu | is_load | is_store | is_branch;

    assign taken = ((funct3_i == 3'b000) & zero_i) | ((funct3_i == 3'b001) & ~zero_i);

    assign wait_expired = WaitEn && (wait_q == WaitLast);
    assign wait_inc     = WaitEn ? wait_q + 1'b1 : '0;

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;   // any non-waiting cycle clears, so entry into FETCH/MEMORY starts at 0
        timeout_d     = timeout_q;
        retire        = 1'b0;
        pc_write_o    = 1'b0;
        sinal_mux_o   = 1'b0;
        ir_write_o    = 1'b0;
        imem_read_o   = 1'b0;
        dmem_read_o   = 1'b0;
        dmem_write_o  = 1'b0;
        reg_write_o   = 1'b0;
        alu_src_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        alu_op_o      = 2'b00;

        case (state_q)
            StFetch: begin
                imem_read_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    state_d    = StDecode;
                end else if (wait_expired) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StDecode: state_d = legal ? StExecute : StHalt;
            StExecute: begin
                if (is_r || is_ialu) begin
                    alu_src_o = is_ialu;
                    alu_op_o  = 2'b10;
                    state_d   = StWriteback;
                end else if (is_load || is_store) begin
                    alu_src_o = 1'b1;
                    state_d   = StMemory;
                end else if (is_branch) begin
                    alu_op_o    = 2'b01;
                    pc_write_o  = 1'b1;
                    sinal_mux_o = taken;
                    retire      = 1'b1;
                    state_d     = StFetch;
                end else begin
                    state_d = StHalt;
                end
            end
            StMemory: begin
                alu_src_o = 1'b1;
                if (is_load || is_store) begin
                    dmem_read_o  = is_load;
                    dmem_write_o = is_store;
                    if (mem_ready_i) begin
                        if (is_load) begin
                            state_d = StWriteback;
                        end else begin
                            pc_write_o = 1'b1;
                            retire     = 1'b1;
                            state_d    = StFetch;
                        end
                    end else if (wait_expired) begin
                        state_d   = StHalt;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_inc;
                    end
                end else begin
                    state_d = StHalt;
                end
            end
            StWriteback: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = is_load;
                pc_write_o   = 1'b1;
                retire       = 1'b1;
                state_d      = StFetch;
            end
            default: state_d = StHalt;  // HALT and unused codes 5/6
        endcase

        instr_count_d = retire ? instr_count_q + 1'b1 : instr_count_q;

        if (reset_i) begin
            pc_write_o   = 1'b0;
            sinal_mux_o  = 1'b0;
            ir_write_o   = 1'b0;
            imem_read_o  = 1'b0;
            dmem_read_o  = 1'b0;
            dmem_write_o = 1'b0;
            reg_write_o  = 1'b0;
            alu_src_o    = 1'b0;
            mem_to_reg_o = 1'b0;
            alu_op_o     = 2'b00;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= StFetch;
            wait_q        <= '0;
            timeout_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            timeout_q     <= timeout_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state_o       = state_q;
    assign halted_o      = (state_q == StHalt);
    assign timeout_o     = timeout_q;
    assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_pc_control_fsm.sv
// Directed bench for pc_control_fsm (CNT_W=4, WAIT_LIMIT=4). Outputs are packed into obs as
// {state[2:0], pc_write, sinal_mux, ir_write, imem_read, dmem_read, dmem_write, reg_write,
//  alu_src, mem_to_reg, alu_op[1:0], halted, timeout}.
module tb_pc_control_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, sinal_mux, ir_write, imem_read, dmem_read, dmem_write, reg_write;
    logic       alu_src, mem_to_reg, halted, timeout;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic [3:0] instr_count;
    logic [15:0] obs;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_cnt = 4'd0;

    localparam logic [15:0] EFetchR  = 16'b000_0011000_00_00_00;
    localparam logic [15:0] EFetchNr = 16'b000_0001000_00_00_00;
    localparam logic [15:0] EDecode  = 16'b001_0000000_00_00_00;
    localparam logic [15:0] EExecR   = 16'b010_0000000_00_10_00;
    localparam logic [15:0] EExecMem = 16'b010_0000000_10_00_00;
    localparam logic [15:0] EMemLd   = 16'b011_0000100_10_00_00;
    localparam logic [15:0] EMemStR  = 16'b011_1000010_10_00_00;
    localparam logic [15:0] EMemStNr = 16'b011_0000010_10_00_00;
    localparam logic [15:0] EWbR     = 16'b100_1000001_00_00_00;
    localparam logic [15:0] EWbLd    = 16'b100_1000001_01_00_00;
    localparam logic [15:0] EHalt    = 16'b111_0000000_00_00_10;
    localparam logic [15:0] EHaltTo  = 16'b111_0000000_00_00_11;

    pc_control_fsm #(.CNT_W(4), .WAIT_LIMIT(4)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .opcode_i     (opcode),
        .funct3_i     (funct3),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .pc_write_o   (pc_write),
        .sinal_mux_o  (sinal_mux),
        .ir_write_o   (ir_write),
        .imem_read_o  (imem_read),
        .dmem_read_o  (dmem_read),
        .dmem_write_o (dmem_write),
        .reg_write_o  (reg_write),
        .alu_src_o    (alu_src),
        .mem_to_reg_o (mem_to_reg),
        .alu_op_o     (alu_op),
        .state_o      (state),
        .halted_o     (halted),
        .timeout_o    (timeout),
        .instr_count_o(instr_count)
    );

    assign obs = {state, pc_write, sinal_mux, ir_write, imem_read, dmem_read, dmem_write,
                  reg_write, alu_src, mem_to_reg, alu_op, halted, timeout};

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    // Single reset edge; released just after the edge so the next negedge is the first FETCH cycle.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (obs[12:6] !== 7'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b, want 0000000", obs[12:6]);
        end
        @(negedge clock);
        #1;
        n_vec++;
        if (obs !== 16'b000_0000000_00_00_00) begin
            n_err++;
            $display("FAIL reset_state: got %b, want %b", obs, 16'b0);
        end
        n_vec++;
        if (instr_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d, want 0", instr_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_r_type();
        logic        rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ev  [4] = '{EFetchR, EDecode, EExecR, EWbR};
        opcode = 7'b0110011;
        funct3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            mem_ready = rdy[i];
            #1;
            n_vec++;
            if (obs !== ev[i]) begin
                n_err++;
                $display("FAIL r_type cyc%0d: got %b, want %b", i, obs, ev[i]);
            end
        end
        @(posedge clock);
        #1;
        exp_cnt++;
        n_vec++;
        if (instr_count !== exp_cnt || state !== 3'd0) begin
            n_err++;
            $display("FAIL r_type_retire: got cnt=%0d st=%0d, want cnt=%0d st=0",
                     instr_count, state, exp_cnt);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3 [3] = '{3'b000, 3'b001, 3'b001};
        logic       zf [3] = '{1'b1, 1'b1, 1'b0};
        logic       tk [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] ev [3];
        opcode = 7'b1100011;
        for (int b = 0; b < 3; b++) begin
            funct3 = f3[b];
            zero   = zf[b];
            ev[0]  = EFetchR;
            ev[1]  = EDecode;
            ev[2]  = {3'b010, 1'b1, tk[b], 5'b00000, 2'b00, 2'b01, 2'b00};
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                mem_ready = 1'b1;
                #1;
                n_vec++;
                if (obs !== ev[i]) begin
                    n_err++;
                    $display("FAIL branch%0d cyc%0d: got %b, want %b", b, i, obs, ev[i]);
                end
            end
            @(posedge clock);
            #1;
            exp_cnt++;
            n_vec++;
            if (instr_count !== exp_cnt || state !== 3'd0) begin
                n_err++;
                $display("FAIL branch%0d_retire: got cnt=%0d st=%0d, want cnt=%0d st=0",
                         b, instr_count, state, exp_cnt);
            end
        end
    endtask

    task automatic test_load_wait();
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ev  [8] = '{EFetchR, EDecode, EExecMem, EMemLd, EMemLd, EMemLd, EMemLd,
                                 EWbLd};
        opcode = 7'b0000011;
        funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            mem_ready = rdy[i];
            #1;
            n_vec++;
            if (obs !== ev[i]) begin
                n_err++;
                $display("FAIL load_wait cyc%0d: got %b, want %b", i, obs, ev[i]);
            end
        end
        @(posedge clock);
        #1;
        exp_cnt++;
        n_vec++;
        if (instr_count !== exp_cnt || state !== 3'd0) begin
            n_err++;
            $display("FAIL load_retire: got cnt=%0d st=%0d, want cnt=%0d st=0",
                     instr_count, state, exp_cnt);
        end
    endtask

    task automatic test_store();
        logic [15:0] ev [4] = '{EFetchR, EDecode, EExecMem, EMemStR};
        opcode = 7'b0100011;
        funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            mem_ready = 1'b1;
            #1;
            n_vec++;
            if (obs !== ev[i]) begin
                n_err++;
                $display("FAIL store cyc%0d: got %b, want %b", i, obs, ev[i]);
            end
        end
        @(posedge clock);
        #1;
        exp_cnt++;
        n_vec++;
        if (instr_count !== exp_cnt || state !== 3'd0) begin
            n_err++;
            $display("FAIL store_retire: got cnt=%0d st=%0d, want cnt=%0d st=0",
                     instr_count, state, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        opcode = 7'b1111111;
        funct3 = 3'b000;
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            mem_ready = (i < 2) ? 1'b1 : i[0];
            #1;
            n_vec++;
            if (obs !== ((i == 0) ? EFetchR : (i == 1) ? EDecode : EHalt)) begin
                n_err++;
                $display("FAIL illegal cyc%0d: got %b", i, obs);
            end
        end
        n_vec++;
        if (instr_count !== exp_cnt) begin
            n_err++;
            $display("FAIL illegal_count: got %0d, want %0d", instr_count, exp_cnt);
        end
        // Branch opcode with an unsupported funct3 must halt too.
        opcode = 7'b1100011;
        funct3 = 3'b010;
        apply_reset();
        exp_cnt = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            mem_ready = 1'b1;
            #1;
            n_vec++;
            if (obs !== ((i == 0) ? EFetchR : (i == 1) ? EDecode : EHalt)) begin
                n_err++;
                $display("FAIL bad_funct3 cyc%0d: got %b", i, obs);
            end
            if (i == 0) begin
                n_vec++;
                if (instr_count !== 4'd0) begin
                    n_err++;
                    $display("FAIL illegal_reset_count: got %0d, want 0", instr_count);
                end
            end
        end
        apply_reset();
    endtask

    task automatic test_timeouts();
        logic        rdy1 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] ev1  [5] = '{EFetchNr, EFetchNr, EFetchNr, EFetchNr, EHaltTo};
        logic        rdy2 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ev2  [5] = '{EFetchNr, EFetchNr, EFetchNr, EFetchR, EDecode};
        logic        rdy3 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] ev3  [8] = '{EFetchR, EDecode, EExecMem, EMemLd, EMemLd, EMemLd, EMemLd,
                                  EHaltTo};
        opcode = 7'b0110011;
        funct3 = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            mem_ready = rdy1[i];
            #1;
            n_vec++;
            if (obs !== ev1[i]) begin
                n_err++;
                $display("FAIL fetch_timeout cyc%0d: got %b, want %b", i, obs, ev1[i]);
            end
        end
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            mem_ready = rdy2[i];
            #1;
            n_vec++;
            if (obs !== ev2[i]) begin
                n_err++;
                $display("FAIL fetch_ready_at_limit cyc%0d: got %b, want %b", i, obs, ev2[i]);
            end
        end
        apply_reset();
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            mem_ready = rdy3[i];
            #1;
            n_vec++;
            if (obs !== ev3[i]) begin
                n_err++;
                $display("FAIL mem_timeout cyc%0d: got %b, want %b", i, obs, ev3[i]);
            end
        end
        n_vec++;
        if (instr_count !== 4'd0) begin
            n_err++;
            $display("FAIL mem_timeout_count: got %0d, want 0", instr_count);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_store();
        logic        rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ev  [4] = '{EFetchR, EDecode, EExecMem, EMemStNr};
        opcode = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            mem_ready = rdy[i];
            #1;
            n_vec++;
            if (obs !== ev[i]) begin
                n_err++;
                $display("FAIL mid_store cyc%0d: got %b, want %b", i, obs, ev[i]);
            end
        end
        @(negedge clock);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_vec++;
        if (dmem_write !== 1'b0 || pc_write !== 1'b0 || state !== 3'd3) begin
            n_err++;
            $display("FAIL mid_store_reset: got dw=%b pcw=%b st=%0d, want dw=0 pcw=0 st=3",
                     dmem_write, pc_write, state);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (state !== 3'd0 || instr_count !== 4'd0) begin
            n_err++;
            $display("FAIL mid_store_after: got st=%0d cnt=%0d, want st=0 cnt=0",
                     state, instr_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        opcode    = 7'b1100011;
        funct3    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (45) @(posedge clock);
        #1;
        n_vec++;
        if (instr_count !== 4'hF || state !== 3'd0) begin
            n_err++;
            $display("FAIL wrap_pre: got cnt=%0d st=%0d, want cnt=15 st=0", instr_count, state);
        end
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if (instr_count !== 4'd0) begin
            n_err++;
            $display("FAIL wrap: got cnt=%0d, want 0", instr_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 7'b0110011;
        funct3    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_r_type();
        test_branch();
        test_load_wait();
        test_store();
        test_illegal();
        test_timeouts();
        test_reset_mid_store();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_control_fsm.md
Name: pc_control_fsm

Overview:
- Multi-cycle control FSM that sequences the PC/next-address unit and the surrounding datapath for the RV32I subset the core supports.
- Generates the PC update strobe and the PC+4 / PC+imm select (sinal_mux), plus instruction-register, memory and register-file strobes.
- Handles variable-latency memory through a ready handshake, counts retired instructions, and halts on illegal opcodes or memory timeout.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- WAIT_LIMIT, 16, max cycles spent waiting for mem_ready in one access before timeout; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12] from the instruction register.
- zero  in  1  ALU zero flag, valid in EXECUTE.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  PC register loads the next address this cycle.
- sinal_mux  out  1  next-PC select: 0 = PC+4, 1 = PC+imm.
- ir_write  out  1  instruction register captures fetched word.
- imem_read  out  1  instruction fetch request.
- dmem_read  out  1  data load request.
- dmem_write  out  1  data store request.
- reg_write  out  1  register-file write enable.
- alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- mem_to_reg  out  1  writeback source: 0 = ALU, 1 = load data.
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- state  out  3  current state encoding.
- halted  out  1  high in HALT.
- timeout  out  1  sticky; set when HALT was entered through a memory timeout.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Registered elements are the state, wait counter, timeout flag and instr_count. All other outputs are combinational from the state and the current inputs.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=7. Codes 5 and 6 go to HALT on the next edge.
- Reset: state=FETCH, instr_count=0, timeout=0, wait counter=0. Every strobe is forced to 0 in any cycle where reset=1. Reset overrides every state, including HALT and a pending memory wait.
- Legal opcodes:
  - R 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011, only with funct3 000 (beq) or 001 (bne)
- FETCH:
  - imem_read=1.
  - On mem_ready=1: ir_write=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Illegal opcode or branch funct3: go to HALT.
  - Otherwise go to EXECUTE. No strobes.
- EXECUTE:
  - R: alu_src=0, alu_op=10, go to WRITEBACK.
  - I-ALU: alu_src=1, alu_op=10, go to WRITEBACK.
  - LOAD/STORE: alu_src=1, alu_op=00, go to MEMORY.
  - BRANCH: alu_src=0, alu_op=01, pc_write=1. taken = (funct3==000 & zero) | (funct3==001 & ~zero). sinal_mux=taken. Retire, go to FETCH.
- MEMORY:
  - Hold the EXECUTE alu_src/alu_op values.
  - LOAD: dmem_read=1; on mem_ready=1 go to WRITEBACK.
  - STORE: dmem_write=1; on mem_ready=1: pc_write=1, sinal_mux=0, retire, go to FETCH.
- WRITEBACK:
  - reg_write=1, mem_to_reg=1 for LOAD (else 0), pc_write=1, sinal_mux=0.
  - Retire, go to FETCH.
- HALT:
  - All strobes 0, halted=1.
  - Stays in HALT until reset.
- sinal_mux is 0 whenever pc_write=0.
- Retire means instr_count increments by 1 on that edge. It wraps from all-ones to 0 with no flag.
- Wait counter (WAIT_LIMIT > 0):
  - Clears on entry to FETCH or MEMORY.
  - Increments each cycle spent waiting there with mem_ready=0.
  - If it reaches WAIT_LIMIT while mem_ready=0, the next state is HALT and timeout is set.
  - mem_ready=1 in the same cycle the limit is reached takes priority, and the access completes.
- mem_ready is ignored outside FETCH and MEMORY.
- Latency with mem_ready tied high:
  - R/I-ALU: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH: 3 cycles

Test Plan:
- Reset then R-type 0110011, mem_ready=1 → states 0,1,2,4,0. pc_write=1, sinal_mux=0 and reg_write=1 only in WRITEBACK. instr_count 0→1.
- beq (funct3=000, zero=1) → pc_write=1 and sinal_mux=1 in EXECUTE, 3 cycles. bne with zero=1 → sinal_mux=0. instr_count +1 each.
- LOAD with mem_ready low for 3 cycles in MEMORY → dmem_read held 4 cycles, then WRITEBACK with mem_to_reg=1 and reg_write=1. Total 8 cycles.
- Opcode 1111111 in DECODE → HALT, halted=1, timeout=0, all strobes 0. Stays for 20 cycles. Reset returns to FETCH with instr_count=0.
- WAIT_LIMIT=4, mem_ready stuck 0 in FETCH → HALT after 4 wait cycles, timeout=1. Repeat with mem_ready=1 on the 4th cycle → DECODE, timeout=0.
- Reset asserted mid-MEMORY of a STORE → dmem_write=0 in that cycle, state=FETCH next edge, no retire. Preload instr_count to all-ones (CNT_W=4) and retire → wraps to 0.
